// File: rtl/inst_fetch.sv
// Instruction fetch and issue unit: holds the PC, fetches over a req/ack
// handshake, latches the instruction register and computes the next PC.
module inst_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0040_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [5:0]  Op,
  output logic [4:0]  Rs,
  output logic [4:0]  Rt,
  output logic [4:0]  Rd,
  output logic [5:0]  Funct,
  output logic [15:0] Imm,
  output logic        inst_valid,
  input  logic        ex_done,
  input  logic        Branch,
  input  logic        Jump,
  input  logic        Zero,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  output logic        illegal_op
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] FETCH = 2'd1;
  localparam logic [1:0] ISSUE = 2'd2;
  localparam logic [1:0] HALT  = 2'd3;

  localparam logic [31:0] resetPcAligned = {RESET_PC[31:2], 2'b00};

  logic [1:0]  state;
  logic [31:0] ir;
  logic [31:0] nextPc;
  logic [31:0] branchOffset;
  logic        opLegal;

  assign pc_plus4  = pc + 32'd4;
  assign imem_addr = pc;

  assign Op    = ir[31:26];
  assign Rs    = ir[25:21];
  assign Rt    = ir[20:16];
  assign Rd    = ir[15:11];
  assign Funct = ir[5:0];
  assign Imm   = ir[15:0];

  assign branchOffset = {{14{ir[15]}}, ir[15:0], 2'b00};

  // Supported opcodes: R-type, lw, sw, beq, j.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    opLegal = 1'b0;
    case (imem_rdata[31:26])
      6'h00, 6'h23, 6'h2B, 6'h04, 6'h02: opLegal = 1'b1;
      default:                           opLegal = 1'b0;
    endcase
  end

  // Jump beats a taken branch when both are asserted.
  always_comb begin
    nextPc = pc_plus4;
    if (Jump)
      nextPc = {pc_plus4[31:28], ir[25:0], 2'b00};
    else if (Branch && Zero)
      nextPc = pc_plus4 + branchOffset;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      state      <= IDLE;
      pc         <= resetPcAligned;
      ir         <= '0;
      imem_req   <= 1'b0;
      inst_valid <= 1'b0;
      illegal_op <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          state    <= FETCH;
          imem_req <= 1'b1;
        end
        FETCH: begin
          if (imem_ack) begin
            ir       <= imem_rdata;
            imem_req <= 1'b0;
            if (opLegal) begin
              state      <= ISSUE;
              inst_valid <= 1'b1;
            end else begin
              state      <= HALT;
              illegal_op <= 1'b1;
            end
          end
        end
        ISSUE: begin
          if (ex_done) begin
            pc         <= nextPc;
            inst_valid <= 1'b0;
            imem_req   <= 1'b1;
            state      <= FETCH;
          end
        end
        HALT: begin
          imem_req   <= 1'b0;
          inst_valid <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_inst_fetch.sv
// Directed bench for inst_fetch: fetch, branch, jump, slow memory,
// illegal opcode and asynchronous reset scenarios.
module tb_inst_fetch;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic [5:0]  Op;
  logic [4:0]  Rs, Rt, Rd;
  logic [5:0]  Funct;
  logic [15:0] Imm;
  logic        inst_valid;
  logic        ex_done;
  logic        Branch, Jump, Zero;
  logic [31:0] pc, pc_plus4;
  logic        illegal_op;

  logic        wReq, wValid, wIllegal;
  logic [31:0] wAddr, wPc, wPcPlus4;
  logic [5:0]  wOp, wFunct;
  logic [4:0]  wRs, wRt, wRd;
  logic [15:0] wImm;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  inst_fetch #(.RESET_PC(32'h0040_0000)) dut (
    .clk(clk), .rst_n(rst_n),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .Op(Op), .Rs(Rs), .Rt(Rt), .Rd(Rd), .Funct(Funct), .Imm(Imm),
    .inst_valid(inst_valid), .ex_done(ex_done),
    .Branch(Branch), .Jump(Jump), .Zero(Zero),
    .pc(pc), .pc_plus4(pc_plus4), .illegal_op(illegal_op)
  );

  // Second instance: unaligned reset PC at the top of the address space.
  inst_fetch #(.RESET_PC(32'hFFFF_FFFF)) dutWrap (
    .clk(clk), .rst_n(rst_n),
    .imem_req(wReq), .imem_addr(wAddr),
    .imem_ack(1'b0), .imem_rdata(32'h0),
    .Op(wOp), .Rs(wRs), .Rt(wRt), .Rd(wRd), .Funct(wFunct), .Imm(wImm),
    .inst_valid(wValid), .ex_done(1'b0),
    .Branch(1'b0), .Jump(1'b0), .Zero(1'b0),
    .pc(wPc), .pc_plus4(wPcPlus4), .illegal_op(wIllegal)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_fetch(input logic [31:0] word);
    imem_ack   = 1'b1;
    imem_rdata = word;
    step();
    imem_ack   = 1'b0;
    imem_rdata = 32'hDEAD_BEEF;
  endtask

  task automatic do_exec(input logic b, input logic j, input logic z);
    Branch  = b;
    Jump    = j;
    Zero    = z;
    ex_done = 1'b1;
    step();
    ex_done = 1'b0;
    Branch  = 1'b0;
    Jump    = 1'b0;
    Zero    = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    imem_ack = 1'b0; imem_rdata = 32'h0; ex_done = 1'b0;
    Branch = 1'b0; Jump = 1'b0; Zero = 1'b0;
    repeat (3) step();
    checks++;
    if (imem_req !== 1'b0 || inst_valid !== 1'b0 || illegal_op !== 1'b0) begin
      errors++;
      $display("FAIL reset_flags: req=%b valid=%b illegal=%b required 0 0 0", imem_req, inst_valid, illegal_op);
    end
    checks++;
    if (pc !== 32'h0040_0000 || Op !== 6'h0 || Imm !== 16'h0) begin
      errors++;
      $display("FAIL reset_pc_fields: pc=%h op=%h imm=%h required 00400000 00 0000", pc, Op, Imm);
    end
    checks++;
    if (wPc !== 32'hFFFF_FFFC || wPcPlus4 !== 32'h0) begin
      errors++;
      $display("FAIL reset_align_wrap: pc=%h pc_plus4=%h required fffffffc 00000000", wPc, wPcPlus4);
    end
    rst_n = 1'b1;
    checks++;
    if (imem_req !== 1'b0) begin
      errors++;
      $display("FAIL idle_no_req: req=%b required 0", imem_req);
    end
    step();
    checks++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h0040_0000) begin
      errors++;
      $display("FAIL first_req: req=%b addr=%h required 1 00400000", imem_req, imem_addr);
    end
  endtask

  task automatic test_lw();
    do_fetch(32'h8C08_0004);
    checks++;
    if (Op !== 6'h23 || Rt !== 5'd8 || Imm !== 16'h0004 || inst_valid !== 1'b1 || imem_req !== 1'b0) begin
      errors++;
      $display("FAIL lw_decode: op=%h rt=%0d imm=%h valid=%b req=%b required 23 8 0004 1 0", Op, Rt, Imm, inst_valid, imem_req);
    end
    do_exec(1'b0, 1'b0, 1'b0);
    checks++;
    if (imem_addr !== 32'h0040_0004 || imem_req !== 1'b1 || inst_valid !== 1'b0) begin
      errors++;
      $display("FAIL lw_next: addr=%h req=%b valid=%b required 00400004 1 0", imem_addr, imem_req, inst_valid);
    end
  endtask

  task automatic test_beq();
    do_fetch(32'h1109_FFFE);
    do_exec(1'b1, 1'b0, 1'b1);
    checks++;
    if (imem_addr !== 32'h0040_0000) begin
      errors++;
      $display("FAIL beq_taken: addr=%h required 00400000", imem_addr);
    end
    do_fetch(32'h0000_0000);
    do_exec(1'b0, 1'b0, 1'b0);
    checks++;
    if (imem_addr !== 32'h0040_0004) begin
      errors++;
      $display("FAIL nop_advance: addr=%h required 00400004", imem_addr);
    end
    do_fetch(32'h1109_FFFE);
    do_exec(1'b1, 1'b0, 1'b0);
    checks++;
    if (imem_addr !== 32'h0040_0008) begin
      errors++;
      $display("FAIL beq_not_taken: addr=%h required 00400008", imem_addr);
    end
  endtask

  task automatic test_jump();
    do_fetch(32'h0810_0010);
    checks++;
    if (Op !== 6'h02) begin
      errors++;
      $display("FAIL j_decode: op=%h required 02", Op);
    end
    do_exec(1'b0, 1'b1, 1'b0);
    checks++;
    if (imem_addr !== 32'h0040_0040) begin
      errors++;
      $display("FAIL j_target: addr=%h required 00400040", imem_addr);
    end
    do_fetch(32'h0810_0010);
    do_exec(1'b1, 1'b1, 1'b1);
    checks++;
    if (imem_addr !== 32'h0040_0040) begin
      errors++;
      $display("FAIL j_over_branch: addr=%h required 00400040", imem_addr);
    end
  endtask

  task automatic test_slow_memory();
    for (int i = 0; i < 3; i++) begin
      ex_done = (i == 1);
      step();
      checks++;
      if (imem_req !== 1'b1 || imem_addr !== 32'h0040_0040 || inst_valid !== 1'b0 || pc !== 32'h0040_0040) begin
        errors++;
        $display("FAIL slow_wait%0d: req=%b addr=%h valid=%b pc=%h required 1 00400040 0 00400040", i, imem_req, imem_addr, inst_valid, pc);
      end
    end
    ex_done = 1'b0;
    do_fetch(32'h012A_4020);
    checks++;
    if (Op !== 6'h00 || Rs !== 5'd9 || Rt !== 5'd10 || Rd !== 5'd8 || Funct !== 6'h20 || inst_valid !== 1'b1) begin
      errors++;
      $display("FAIL rtype_decode: op=%h rs=%0d rt=%0d rd=%0d funct=%h valid=%b required 00 9 10 8 20 1", Op, Rs, Rt, Rd, Funct, inst_valid);
    end
    do_exec(1'b0, 1'b0, 1'b0);
    checks++;
    if (imem_addr !== 32'h0040_0044 || imem_req !== 1'b1) begin
      errors++;
      $display("FAIL slow_next: addr=%h req=%b required 00400044 1", imem_addr, imem_req);
    end
  endtask

  task automatic test_reset_mid_fetch();
    rst_n = 1'b0;
    #1;
    checks++;
    if (imem_req !== 1'b0 || pc !== 32'h0040_0000 || Rd !== 5'd0 || Funct !== 6'h0) begin
      errors++;
      $display("FAIL reset_fetch_async: req=%b pc=%h rd=%0d funct=%h required 0 00400000 0 00", imem_req, pc, Rd, Funct);
    end
    step();
    rst_n = 1'b1;
    step();
    checks++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h0040_0000) begin
      errors++;
      $display("FAIL restart_fetch: req=%b addr=%h required 1 00400000", imem_req, imem_addr);
    end
  endtask

  task automatic test_reset_mid_issue();
    do_fetch(32'h8C08_0004);
    rst_n = 1'b0;
    #1;
    checks++;
    if (inst_valid !== 1'b0 || imem_req !== 1'b0 || Rt !== 5'd0 || Imm !== 16'h0) begin
      errors++;
      $display("FAIL reset_issue_async: valid=%b req=%b rt=%0d imm=%h required 0 0 0 0000", inst_valid, imem_req, Rt, Imm);
    end
    step();
    rst_n = 1'b1;
    step();
    checks++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h0040_0000) begin
      errors++;
      $display("FAIL restart_issue: req=%b addr=%h required 1 00400000", imem_req, imem_addr);
    end
  endtask

  task automatic test_illegal();
    do_fetch(32'h2008_0001);
    checks++;
    if (illegal_op !== 1'b1 || inst_valid !== 1'b0 || imem_req !== 1'b0 || Op !== 6'h08) begin
      errors++;
      $display("FAIL illegal_flag: illegal=%b valid=%b req=%b op=%h required 1 0 0 08", illegal_op, inst_valid, imem_req, Op);
    end
    for (int i = 0; i < 22; i++) begin
      ex_done  = i[0];
      imem_ack = ~i[0];
      step();
      checks++;
      if (imem_req !== 1'b0 || inst_valid !== 1'b0 || illegal_op !== 1'b1 || pc !== 32'h0040_0000) begin
        errors++;
        $display("FAIL halt_hold%0d: req=%b valid=%b illegal=%b pc=%h required 0 0 1 00400000", i, imem_req, inst_valid, illegal_op, pc);
      end
    end
    ex_done  = 1'b0;
    imem_ack = 1'b0;
  endtask

  initial begin
    test_reset();
    test_lw();
    test_beq();
    test_jump();
    test_slow_memory();
    test_reset_mid_fetch();
    test_reset_mid_issue();
    test_illegal();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
